// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: one 32-bit load/store as two half-word accesses on a
// 16-bit asynchronous SRAM, freezing the pipeline via `ready` while busy.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic [31:0] mem_rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   offset;
  logic [16:0]   word;
  logic          req;
  logic          is_store;
  logic          last;
  logic [15:0]   lo_buf;
  logic [31:0]   rdata_q;

  assign offset   = addr - DATA_BASE;
  assign word     = 17'(offset >> 2);
  assign req      = mem_r_en | mem_w_en;
  assign is_store = mem_w_en;
  assign last     = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = LO;
          cnt_next   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_next = HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HI: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded straight from state so a reset drops them at once.
  always_comb begin
    ready       = 1'b1;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      IDLE: ready = ~req;
      LO, HI: begin
        ready     = 1'b0;
        sram_addr = {word, state == HI};
        if (is_store) begin
          sram_dq_oe  = 1'b1;
          // Release WE one cycle early for data hold, unless only one cycle exists.
          sram_we_n   = (WAIT_CYCLES > 1) ? last : 1'b0;
          sram_dq_out = (state == HI) ? st_data[31:16] : st_data[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Low half is staged so mem_rdata only changes when a whole load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_buf  <= '0;
      rdata_q <= '0;
    end else if (!is_store && last) begin
      if (state == LO) lo_buf <= sram_dq_in;
      if (state == HI) rdata_q <= {sram_dq_in, lo_buf};
    end
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM.
module tb_mem_stage_sram_ctrl;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk;
  logic        rst_n;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] mem_rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [64];
  logic [15:0] ref_mem  [64];
  logic [31:0] exp_rdata;

  typedef struct {
    logic        ready;
    logic [17:0] addr;
    logic        we_n;
    logic        oe_n;
    logic        dq_oe;
    logic        chk_dq;
    logic [15:0] dq_out;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .DATA_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .st_data(st_data), .mem_rdata(mem_rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[5:0]] <= sram_dq_out;

  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[5:0]];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Builds the expected per-cycle picture from the reference model, then drives it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [16:0] w;
    logic [5:0]  lo_i;
    logic [5:0]  hi_i;
    exp_t        e;
    w    = 17'((a - BASE) >> 2);
    lo_i = 6'({w, 1'b0});
    hi_i = 6'({w, 1'b1});
    if (wr) begin
      ref_mem[lo_i] = d[15:0];
      ref_mem[hi_i] = d[31:16];
    end else if (rd) begin
      exp_rdata = {ref_mem[hi_i], ref_mem[lo_i]};
    end
    for (int c = 0; c <= 2*W + 1; c++) begin
      e = '{ready: 1'b0, addr: 18'd0, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0,
            chk_dq: 1'b0, dq_out: 16'h0, chk_rd: 1'b0, rdata: 32'h0};
      if (c >= 1 && c <= 2*W) begin
        int  k;
        logic hi;
        hi     = (c > W);
        k      = hi ? c - W - 1 : c - 1;
        e.addr = {w, hi};
        if (wr) begin
          e.dq_oe  = 1'b1;
          e.we_n   = (W > 1) && (k == W - 1);
          e.chk_dq = 1'b1;
          e.dq_out = hi ? d[31:16] : d[15:0];
        end else begin
          e.oe_n = 1'b0;
        end
      end
      if (c == 2*W + 1) begin
        e.ready  = 1'b1;
        e.chk_rd = 1'b1;
        e.rdata  = exp_rdata;
      end
      sb.push_back(e);
    end
    mem_r_en = rd;
    mem_w_en = wr;
    addr     = a;
    st_data  = d;
    for (int c = 0; c <= 2*W + 1; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      checkOutput($sformatf("a%0d c%0d ready", a, c), 32'(ready), 32'(e.ready));
      checkOutput($sformatf("a%0d c%0d sram_addr", a, c), 32'(sram_addr), 32'(e.addr));
      checkOutput($sformatf("a%0d c%0d we_n", a, c), 32'(sram_we_n), 32'(e.we_n));
      checkOutput($sformatf("a%0d c%0d oe_n", a, c), 32'(sram_oe_n), 32'(e.oe_n));
      checkOutput($sformatf("a%0d c%0d dq_oe", a, c), 32'(sram_dq_oe), 32'(e.dq_oe));
      if (e.chk_dq) checkOutput($sformatf("a%0d c%0d dq_out", a, c), 32'(sram_dq_out), 32'(e.dq_out));
      if (e.chk_rd) checkOutput($sformatf("a%0d c%0d mem_rdata", a, c), mem_rdata, e.rdata);
      @(posedge clk);
      #1;
    end
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle ready", 32'(ready), 32'd1);
      checkOutput("idle we_n", 32'(sram_we_n), 32'd1);
      checkOutput("idle rdata", mem_rdata, exp_rdata);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = 16'(i * 16'h0101 + 16'h1000);
      ref_mem[i]  = 16'(i * 16'h0101 + 16'h1000);
    end
    exp_rdata = 32'h0;
    rst_n     = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    addr      = 32'h0;
    st_data   = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst ready", 32'(ready), 32'd1);
    checkOutput("rst we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("rst rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(2);

    applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    idleCycles(1);
    applyStimulus(1'b1, 1'b1, 32'd1036, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 32'd1036, 32'h0);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
    idleCycles(3);

    // Store at 1040, aborted by reset during the first HI cycle.
    mem_w_en = 1'b1;
    addr     = 32'd1040;
    st_data  = 32'hCAFE_F00D;
    repeat (W + 1) @(posedge clk);
    #3;
    rst_n    = 1'b0;
    mem_w_en = 1'b0;
    #1;
    checkOutput("abort ready", 32'(ready), 32'd1);
    checkOutput("abort we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("abort rdata", mem_rdata, 32'h0);
    ref_mem[8] = 16'hF00D;
    exp_rdata  = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("abort held we_n", 32'(sram_we_n), 32'd1);
      checkOutput("abort held oe_n", 32'(sram_oe_n), 32'd1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0);
    idleCycles(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
